// File: rtl/knn_ctrl.sv
// Sequencer for one KNN classification: calc launch, sort hand-off, K-cycle vote, argmax select.
// Optional watchdog on the CALC/SORT_WAIT waits is enabled by defining KNN_CTRL_TIMEOUT_EN.
module knn_ctrl #(
    parameter int L           = 5,
    parameter int TYPE_W      = 3,
    parameter int K           = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       ready,
    output logic                       calc_start,
    input  logic                       calc_done,
    output logic                       done_calc,
    input  logic                       valid_sort,
    input  logic [TYPE_W*(1<<L)-1:0]   type_array_sorted,
    output logic [TYPE_W-1:0]          class_out,
    output logic                       class_valid,
    output logic                       error
);

    localparam int NT    = 1 << TYPE_W;
    localparam int CNT_W = $clog2(K + 1);
    localparam logic [L-1:0] IDX_LAST = L'(K - 1);

    if (K < 1 || K > (1 << L) || TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("knn_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SORT_WAIT,
        S_VOTE,
        S_SELECT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [L-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q [NT];
    logic [CNT_W-1:0]    cnt_d [NT];
    logic                calc_start_q, calc_start_d;
    logic                done_calc_q, done_calc_d;
    logic [TYPE_W-1:0]   class_out_q, class_out_d;
    logic                class_valid_q, class_valid_d;
    logic [TYPE_W-1:0]   entry;
    logic [TYPE_W-1:0]   best_lbl;
    logic [CNT_W-1:0]    best_cnt;

`ifdef KNN_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                error_q, error_d;
`endif

    assign entry = type_array_sorted[idx_q*TYPE_W +: TYPE_W];

    // Strict '>' keeps the lowest label on ties and yields 0 when nothing was counted.
    always_comb begin
        best_lbl = '0;
        best_cnt = '0;
        for (int t = 1; t < NT; t++) begin
            if (cnt_q[t] > best_cnt) begin
                best_cnt = cnt_q[t];
                best_lbl = TYPE_W'(t);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        calc_start_d  = 1'b0;
        done_calc_d   = 1'b0;
        class_valid_d = 1'b0;
        class_out_d   = class_out_q;
`ifdef KNN_CTRL_TIMEOUT_EN
        wdog_d        = '0;
        error_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_CALC;
                    calc_start_d = 1'b1;
                end
            end
            S_CALC: begin
                if (calc_done) begin
                    state_d     = S_SORT_WAIT;
                    done_calc_d = 1'b1;
                end
`ifdef KNN_CTRL_TIMEOUT_EN
                else if (wdog_q == WD_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_SORT_WAIT: begin
                if (valid_sort) begin
                    state_d = S_VOTE;
                    idx_d   = '0;
                    for (int t = 0; t < NT; t++) cnt_d[t] = '0;
                end
`ifdef KNN_CTRL_TIMEOUT_EN
                else if (wdog_q == WD_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_VOTE: begin
                // Label 0 marks padding entries and never takes a vote.
                if (entry != '0) cnt_d[entry] = cnt_q[entry] + 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = S_SELECT;
            end
            S_SELECT: begin
                class_out_d   = best_lbl;
                class_valid_d = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            for (int t = 0; t < NT; t++) cnt_q[t] <= '0;
            calc_start_q  <= 1'b0;
            done_calc_q   <= 1'b0;
            class_out_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            calc_start_q  <= calc_start_d;
            done_calc_q   <= done_calc_d;
            class_out_q   <= class_out_d;
            class_valid_q <= class_valid_d;
        end
    end

`ifdef KNN_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign ready       = (state_q == S_IDLE);
    assign calc_start  = calc_start_q;
    assign done_calc   = done_calc_q;
    assign class_out   = class_out_q;
    assign class_valid = class_valid_q;

endmodule

// File: tb/tb_knn_ctrl.sv
// Scoreboard bench for knn_ctrl: directed runs push expected classes, a negedge monitor checks them.
module tb_knn_ctrl;

    localparam int L  = 5;
    localparam int TW = 3;
    localparam int K  = 5;
    localparam int NN = 1 << L;
    localparam int TO = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              ready;
    logic              calc_start;
    logic              calc_done;
    logic              done_calc;
    logic              valid_sort;
    logic [TW*NN-1:0]  tas;
    logic [TW-1:0]     class_out;
    logic              class_valid;
    logic              error;

    knn_ctrl #(.L(L), .TYPE_W(TW), .K(K), .TIMEOUT_CYC(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .ready             (ready),
        .calc_start        (calc_start),
        .calc_done         (calc_done),
        .done_calc         (done_calc),
        .valid_sort        (valid_sort),
        .type_array_sorted (tas),
        .class_out         (class_out),
        .class_valid       (class_valid),
        .error             (error)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int n_cs = 0;
    int n_dc = 0;
    int n_cv = 0;
    int n_err = 0;
    logic [TW-1:0] expq[$];
    logic [TW-1:0] exp_cls;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW*NN-1:0] mk(input int a, input int b, input int c,
                                            input int d, input int e, input int fill);
        logic [TW*NN-1:0] v;
        for (int i = 0; i < NN; i++) v[i*TW +: TW] = TW'(fill);
        v[0*TW +: TW] = TW'(a);
        v[1*TW +: TW] = TW'(b);
        v[2*TW +: TW] = TW'(c);
        v[3*TW +: TW] = TW'(d);
        v[4*TW +: TW] = TW'(e);
        return v;
    endfunction

    // Monitor: pulse counting and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            if (calc_start) n_cs++;
            if (done_calc) n_dc++;
            if (error) n_err++;
            if (class_valid) begin
                n_cv++;
                check("class_valid_expected", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    exp_cls = expq.pop_front();
                    check("class_out", int'(class_out), int'(exp_cls));
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (ready) return;
            @(negedge clk);
        end
        check("ready_timeout", int'(ready), 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_run(input logic [TW*NN-1:0] data, input logic [TW-1:0] expc,
                          input int calc_wait, input int hold_vs, input int start_in_vote);
        int cs0, dc0, err0, lat;
        cs0  = n_cs;
        dc0  = n_dc;
        err0 = n_err;
        wait_ready();
        pulse_start();
        check("ready_after_start", int'(ready), 0);
        repeat (calc_wait) @(posedge clk);
        #1;
        check("busy_in_calc", int'(ready), 0);
        calc_done = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        tas = data;
        expq.push_back(expc);
        valid_sort = 1'b1;
        @(posedge clk); #1;
        if (hold_vs == 0) valid_sort = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (start_in_vote != 0 && n == 2) start = 1'b1;
            if (start_in_vote != 0 && n == 3) start = 1'b0;
            if (class_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, K + 2);
        @(negedge clk);
        check("class_valid_width", int'(class_valid), 0);
        if (hold_vs != 0) repeat (3) @(negedge clk);
        valid_sort = 1'b0;
        repeat (4) @(negedge clk);
        check("calc_start_pulses", n_cs - cs0, 1);
        check("done_calc_pulses", n_dc - dc0, 1);
        check("class_out_held", int'(class_out), int'(expc));
        check("error_pulses", n_err - err0, 0);
        check("ready_at_end", int'(ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench still running at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int cv0, err0, n_hit;
        rst        = 1'b0;
        start      = 1'b0;
        calc_done  = 1'b0;
        valid_sort = 1'b0;
        tas        = '0;
        #12;
        check("rst_ready", int'(ready), 1);
        check("rst_calc_start", int'(calc_start), 0);
        check("rst_done_calc", int'(done_calc), 0);
        check("rst_class_valid", int'(class_valid), 0);
        check("rst_class_out", int'(class_out), 0);
        check("rst_error", int'(error), 0);
        @(posedge clk); #3;
        rst = 1'b1;

        // Scenario 1: majority 1 out of {1,1,2,1,3}.
        do_run(mk(1, 1, 2, 1, 3, 7), 3'd1, 9, 0, 0);

        // Scenario 2: tie 2/3 -> 2; beyond-K entries would tip it to 3; valid_sort held high.
        do_run(mk(2, 3, 3, 2, 0, 3), 3'd2, 9, 1, 0);
        check("class_out_before_rst", int'(class_out), 2);

        // Scenario 4: reset while waiting for the sorter.
        wait_ready();
        cv0 = n_cv;
        pulse_start();
        repeat (9) @(posedge clk);
        #1;
        calc_done = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_class_out", int'(class_out), 0);
        check("abort_class_valid", int'(class_valid), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tas = mk(1, 1, 1, 1, 1, 1);
        @(posedge clk); #1;
        valid_sort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        valid_sort = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_class_valid", n_cv - cv0, 0);
        check("abort_ready_after", int'(ready), 1);
        check("abort_class_out_after", int'(class_out), 0);

        // Scenario 3: all padding -> 0; start pulsed during VOTE is ignored.
        do_run(mk(0, 0, 0, 0, 0, 5), 3'd0, 9, 0, 1);

        // Scenario 1 again after the abort.
        do_run(mk(1, 1, 2, 1, 3, 7), 3'd1, 9, 0, 0);

`ifdef KNN_CTRL_TIMEOUT_EN
        // Scenario 5: watchdog expiry with calc_done withheld.
        wait_ready();
        err0 = n_err;
        cv0  = n_cv;
        pulse_start();
        n_hit = 0;
        for (int n = 1; n <= TO + 50; n++) begin
            @(negedge clk);
            if (error) begin
                n_hit = n;
                break;
            end
        end
        check("timeout_edge", n_hit - 1, TO);
        check("timeout_ready", int'(ready), 1);
        check("timeout_class_out", int'(class_out), 1);
        @(negedge clk);
        check("timeout_error_width", n_err - err0, 1);
        check("timeout_no_class_valid", n_cv - cv0, 0);
`else
        // Scenario 5: without the watchdog the block waits in CALC indefinitely.
        err0 = n_err;
        n_hit = 0;
        do_run(mk(3, 3, 1, 2, 2, 6), 3'd2, 5000, 0, 0);
        check("no_timeout_error", n_err - err0, n_hit);
`endif

        @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
